// File: rtl/modmul_arbiter_if.sv
// Bundle between N requesters, the round-robin arbiter and one shared
// modular-multiplier unit (start/done/result protocol).
interface modmul_arbiter_if #(
  parameter int W  = 260,
  parameter int N  = 4,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*W-1:0] req_m;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_result;
  logic           busy;
  logic [IW-1:0]  grant_id;
  logic           mm_start;
  logic [W-1:0]   mm_a;
  logic [W-1:0]   mm_b;
  logic [W-1:0]   mm_m;
  logic [W-1:0]   mm_result;
  logic           mm_done;

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, req_m, mm_result, mm_done,
    output req_ack, resp_valid, resp_result, busy, grant_id,
           mm_start, mm_a, mm_b, mm_m
  );

  // Requesters plus multiplier side.
  modport master (
    output req_valid, req_a, req_b, req_m, mm_result, mm_done,
    input  req_ack, resp_valid, resp_result, busy, grant_id,
           mm_start, mm_a, mm_b, mm_m
  );
endinterface

// File: rtl/modmul_arbiter.sv
// Round-robin arbiter sharing one modular multiplier among N requesters:
// grant, latch operands, run one start/done transaction, return the product.
module modmul_arbiter #(
  parameter int W  = 260,
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  modmul_arbiter_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  localparam logic [IW:0] N_EXT = (IW+1)'(N);

  state_t         r_state;
  logic [IW-1:0]  r_rr_ptr;
  logic [IW-1:0]  r_grant_id;
  logic           r_mm_start;
  logic           r_busy;
  logic [N-1:0]   r_resp_valid;
  logic [W-1:0]   r_mm_a;
  logic [W-1:0]   r_mm_b;
  logic [W-1:0]   r_mm_m;
  logic [W-1:0]   r_resp_result;

  logic [W-1:0]   w_a [N];
  logic [W-1:0]   w_b [N];
  logic [W-1:0]   w_m [N];
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;
  logic [IW-1:0]  w_grant_idx;
  logic [IW-1:0]  w_ptr_next;
  logic           w_grant_valid;
  logic [N-1:0]   w_grant_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_a[gi] = bus.req_a[gi*W +: W];
      assign w_b[gi] = bus.req_b[gi*W +: W];
      assign w_m[gi] = bus.req_m[gi*W +: W];
    end
  endgenerate

  // Rotate requests so bit 0 is the requester at rr_ptr; lowest set bit wins.
  assign w_rot = N'({bus.req_valid, bus.req_valid} >> r_rr_ptr);

  always_comb begin
    w_off = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
  end

  assign w_sum          = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_grant_idx    = (w_sum >= N_EXT) ? IW'(w_sum - N_EXT) : IW'(w_sum);
  assign w_ptr_next     = (w_grant_idx == IW'(N-1)) ? '0 : w_grant_idx + 1'b1;
  assign w_grant_valid  = |bus.req_valid;
  assign w_grant_onehot = N'(1) << w_grant_idx;

  // Ack is combinational so the requester sees it in the arbitration cycle.
  assign bus.req_ack = (r_state == S_IDLE && w_grant_valid && !reset) ? w_grant_onehot : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_mm_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_resp_valid  <= '0;
      r_mm_a        <= '0;
      r_mm_b        <= '0;
      r_mm_m        <= '0;
      r_resp_result <= '0;
    end else begin
      r_mm_start   <= 1'b0;
      r_resp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_mm_a     <= w_a[w_grant_idx];
            r_mm_b     <= w_b[w_grant_idx];
            r_mm_m     <= w_m[w_grant_idx];
            r_grant_id <= w_grant_idx;
            r_rr_ptr   <= w_ptr_next;
            r_mm_start <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT_BUSY;
        // Ignore the done level left over from the previous run.
        S_WAIT_BUSY: begin
          if (!bus.mm_done) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (bus.mm_done) begin
            r_resp_result <= bus.mm_result;
            r_resp_valid  <= N'(1) << r_grant_id;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_result = r_resp_result;
  assign bus.busy        = r_busy;
  assign bus.grant_id    = r_grant_id;
  assign bus.mm_start    = r_mm_start;
  assign bus.mm_a        = r_mm_a;
  assign bus.mm_b        = r_mm_b;
  assign bus.mm_m        = r_mm_m;
endmodule

// File: tb/tb_modmul_arbiter.sv
// Bench for modmul_arbiter: behavioural multiplier with configurable stale-done
// and run phases, requester models and a cycle-level reference of the arbiter.
module tb_modmul_arbiter;
  localparam int W = 260;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  modmul_arbiter_if #(.W(W), .N(N)) bus ();

  modmul_arbiter #(.W(W), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [2*W-1:0] p;
    if (m == '0) return '0;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(p % {{W{1'b0}}, m});
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v = '0;
    for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom);
    return v;
  endfunction

  // Multiplier model: after sampling start, done stays high for mm_stale cycles
  // showing the previous result, low for mm_run cycles, then high with the product.
  int           mm_stale = 0;
  int           mm_run   = 2;
  logic         mm_active = 1'b0;
  int           mm_t = 0;
  logic [W-1:0] mm_prod = '0;
  logic [W-1:0] mm_prev = '0;

  always @(posedge clk) begin
    if (reset) begin
      mm_active <= 1'b0;
      mm_t      <= 0;
      mm_prod   <= '0;
      mm_prev   <= '0;
    end else if (bus.mm_start) begin
      mm_active <= 1'b1;
      mm_t      <= 1;
      mm_prev   <= mm_prod;
      mm_prod   <= mod_mul(bus.mm_a, bus.mm_b, bus.mm_m);
    end else if (mm_active) begin
      if (mm_t > mm_stale + mm_run) mm_active <= 1'b0;
      else mm_t <= mm_t + 1;
    end
  end

  assign bus.mm_done   = !mm_active || (mm_t <= mm_stale) || (mm_t > mm_stale + mm_run);
  assign bus.mm_result = !mm_active ? mm_prod :
                         (mm_t <= mm_stale) ? mm_prev :
                         (mm_t > mm_stale + mm_run) ? mm_prod : ~mm_prod;

  // Requester state
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic [W-1:0] op_m [N];
  logic [W-1:0] base_a [N];
  logic [W-1:0] base_b [N];
  logic [W-1:0] base_m [N];
  logic [N-1:0] drv_valid = '0;
  int           rearm_left [N];
  bit           fixed_ops = 1'b0;
  int           ack_who = -1;
  int           resp_who = -1;

  // Reference model state
  int           cyc = 0;
  bit           m_active = 1'b0;
  int           m_grant = 0;
  int           m_ptr = 0;
  int           m_ack_cyc = -10;
  int           m_resp_cyc = -1;
  logic [W-1:0] m_ea, m_eb, m_em, m_exp;
  logic [W-1:0] m_last = '0;
  int           grant_log [$];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic new_ops(input int i);
    if (fixed_ops) begin
      op_a[i] = base_a[i];
      op_b[i] = base_b[i];
      op_m[i] = base_m[i];
    end else begin
      op_a[i] = rand_w();
      op_b[i] = rand_w();
      op_m[i] = rand_w() >> $urandom_range(0, W - 2);
      if (op_m[i] == '0) op_m[i] = 1;
    end
  endtask

  task automatic drive();
    bus.req_valid = drv_valid;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = op_a[i];
      bus.req_b[i*W +: W] = op_b[i];
      bus.req_m[i*W +: W] = op_m[i];
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0] exp_ack;
    logic [N-1:0] exp_resp;
    int g;
    if (reset) begin
      check("rst_busy", bus.busy, 0);
      check("rst_req_ack", bus.req_ack, 0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_mm_start", bus.mm_start, 0);
      check("rst_grant_id", bus.grant_id, 0);
      check("rst_mm_a", bus.mm_a, 0);
      check("rst_mm_b", bus.mm_b, 0);
      check("rst_mm_m", bus.mm_m, 0);
      check("rst_resp_result", bus.resp_result, 0);
      return;
    end
    // Expected grant: first requester at or after the pointer, wrapping.
    exp_ack = '0;
    g = -1;
    if (!m_active) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && drv_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      if (g >= 0) exp_ack[g] = 1'b1;
    end
    check("req_ack", bus.req_ack, exp_ack);
    check("busy", bus.busy, m_active);
    check("mm_start", bus.mm_start, m_active && (cyc == m_ack_cyc + 1));
    if (m_active) begin
      check("grant_id", bus.grant_id, m_grant);
      check("mm_a", bus.mm_a, m_ea);
      check("mm_b", bus.mm_b, m_eb);
      check("mm_m", bus.mm_m, m_em);
      if (cyc == m_ack_cyc + 1) m_resp_cyc = cyc + mm_stale + mm_run + 2;
    end
    exp_resp = '0;
    if (m_active && cyc == m_resp_cyc) exp_resp[m_grant] = 1'b1;
    check("resp_valid", bus.resp_valid, exp_resp);
    if (exp_resp != '0) begin
      m_last = m_exp;
      $display("[TB] cycle %0d: resp req=%0d result=%0h", cyc, m_grant, bus.resp_result);
      m_active = 1'b0;
      resp_who = m_grant;
    end
    check("resp_result", bus.resp_result, m_last);
    if (g >= 0) begin
      m_active   = 1'b1;
      m_grant    = g;
      m_ptr      = (g + 1) % N;
      m_ea       = op_a[g];
      m_eb       = op_b[g];
      m_em       = op_m[g];
      m_exp      = mod_mul(op_a[g], op_b[g], op_m[g]);
      m_ack_cyc  = cyc;
      m_resp_cyc = -1;
      ack_who    = g;
      grant_log.push_back(g);
    end
  endtask

  // One clock: apply requester reactions after the edge, check at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (ack_who >= 0) begin
      // Operands change after the ack; the latched copy must not follow.
      drv_valid[ack_who] = 1'b0;
      op_a[ack_who] = '0;
      op_b[ack_who] = rand_w();
      op_m[ack_who] = rand_w() | 1;
      ack_who = -1;
    end
    if (resp_who >= 0) begin
      if (rearm_left[resp_who] > 0) begin
        rearm_left[resp_who]--;
        new_ops(resp_who);
        drv_valid[resp_who] = 1'b1;
      end
      resp_who = -1;
    end
    drive();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    drv_valid = '0;
    m_active  = 1'b0;
    m_ptr     = 0;
    m_last    = '0;
    ack_who   = -1;
    resp_who  = -1;
    for (int i = 0; i < N; i++) rearm_left[i] = 0;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((drv_valid != '0 || m_active || ack_who >= 0 || resp_who >= 0) && n < budget) begin
      step();
      n++;
    end
    check("idle_within_budget", n < budget, 1'b1);
  endtask

  initial begin
    int exp_fair [6] = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_m[i] = '0;
      rearm_left[i] = 0;
    end
    drive();
    do_reset(3);

    // Single request
    mm_stale = 0; mm_run = 3;
    fixed_ops = 1'b1;
    op_a[0] = 3; op_b[0] = 5; op_m[0] = 7;
    drv_valid = 4'b0001;
    wait_idle(100);
    check("single_result", bus.resp_result, 1);
    check("single_busy_after", bus.busy, 0);

    // Fairness with continuous requests
    do_reset(2);
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      base_a[i] = W'(i + 2); base_b[i] = 10; base_m[i] = 13;
      new_ops(i);
    end
    rearm_left[0] = 1; rearm_left[1] = 1;
    drv_valid = 4'b1111;
    wait_idle(300);
    check("fair_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) check("fair_order", grant_log[i], exp_fair[i]);

    // Pointer rotation: serve 2, then 0 and 2 together
    drv_valid = 4'b0100;
    wait_idle(100);
    grant_log.delete();
    drv_valid = 4'b0101;
    wait_idle(100);
    check("rot_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("rot_first", grant_log[0], 0);
      check("rot_second", grant_log[1], 2);
    end

    // Stale done level from the multiplier
    fixed_ops = 1'b0;
    mm_stale = 3; mm_run = 6;
    new_ops(1);
    drv_valid = 4'b0010;
    wait_idle(100);
    new_ops(3);
    drv_valid = 4'b1000;
    wait_idle(100);

    // Reset while waiting on the multiplier
    mm_stale = 0; mm_run = 10;
    new_ops(2);
    drv_valid = 4'b0100;
    for (int n = 0; n < 50 && !(m_active && cyc >= m_ack_cyc + 4); n++) step();
    check("reached_wait_done", m_active && (cyc >= m_ack_cyc + 4), 1'b1);
    do_reset(1);
    repeat (15) step();
    grant_log.delete();
    new_ops(0); new_ops(3);
    mm_run = 2;
    drv_valid = 4'b1001;
    wait_idle(100);
    check("post_rst_count", grant_log.size(), 2);
    if (grant_log.size() > 0) check("post_rst_first", grant_log[0], 0);

    // Randomized rounds
    for (int r = 0; r < 20; r++) begin
      mm_stale = $urandom_range(0, 2);
      mm_run   = $urandom_range(1, 5);
      for (int i = 0; i < N; i++) begin
        new_ops(i);
        rearm_left[i] = $urandom_range(0, 2);
      end
      drv_valid = N'($urandom);
      wait_idle(1000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
